// File: rtl/adder_stream.sv
// adder_stream: valid/ready front end for the 16-bit adder stage.
// Tags operations through the adder latency and buffers sums in a credit-gated FIFO.
module adder_stream #(
    parameter int LATENCY = 1,
    parameter int DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_add_a,
    output logic [15:0] o_add_b,
    input  logic [16:0] i_add_sum,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [16:0] o_sum
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = AW + 1;

    logic          accept;
    logic          pop;
    logic          fifo_push;
    logic          fifo_full;
    logic          fifo_empty;

    logic [LATENCY:0] tag_q;
    logic [LATENCY:0] tag_d;

    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] wr_ptr_d;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] rd_ptr_d;

    logic [16:0]   mem_q [DEPTH];

    logic [CW-1:0] total_q;
    logic [CW-1:0] total_d;
    logic          ready_q;
    logic          ready_d;

    logic [15:0]   a_q;
    logic [15:0]   a_d;
    logic [15:0]   b_q;
    logic [15:0]   b_d;

    // Handshake qualifiers and FIFO status, all from registered state.
    always_comb begin
        accept     = i_valid & ready_q;
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW])
                   && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop        = ~fifo_empty & i_ready;
        fifo_push  = tag_q[LATENCY];
    end

    // Operand registers load on accept and otherwise hold.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (accept) begin
            a_d = i_a;
            b_d = i_b;
        end
    end

    // Tag pipe marks which adder outputs belong to accepted operations.
    always_comb begin
        tag_d = {tag_q[LATENCY-1:0], accept};
    end

    // FIFO pointer advance on push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (fifo_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    // Credit count of in-flight plus buffered results gates o_ready.
    always_comb begin
        total_d = total_q;
        unique case ({accept, pop})
            2'b10:   total_d = total_q + CW'(1);
            2'b01:   total_d = total_q - CW'(1);
            default: total_d = total_q;
        endcase
        ready_d = (total_d < CW'(DEPTH));
    end

    // Control state: tags, pointers, credits, ready and operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            total_q  <= '0;
            ready_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            tag_q    <= tag_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            total_q  <= total_d;
            ready_q  <= ready_d;
            a_q      <= a_d;
            b_q      <= b_d;
        end
    end

    // Result storage; cleared so the head reads zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (fifo_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_add_sum;
        end
    end

    assign o_ready = ready_q;
    assign o_add_a = a_q;
    assign o_add_b = b_q;
    assign o_valid = ~fifo_empty;
    assign o_sum   = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: tb/tb_adder_stream.sv
// tb_adder_stream: directed checks on the default build plus
// scoreboarded random traffic on a LATENCY=3, DEPTH=8 build.
module tb_adder_stream;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        v0, r0, o_ready0, o_valid0;
    logic [15:0] a0, b0, o_add_a0, o_add_b0;
    logic [16:0] sum_in0, o_sum0;

    logic        v1, r1, o_ready1, o_valid1;
    logic [15:0] a1, b1, o_add_a1, o_add_b1;
    logic [16:0] sum_in1, o_sum1;

    logic [16:0] add0_q;
    logic [16:0] add1_q [3];

    int          ntests = 0;
    int          nfail  = 0;
    int          k;
    int          rx;
    logic [16:0] exp_q [$];
    int          cyc_q [$];

    always #5 clk = ~clk;

    adder_stream dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_valid   (v0),
        .o_ready   (o_ready0),
        .i_a       (a0),
        .i_b       (b0),
        .o_add_a   (o_add_a0),
        .o_add_b   (o_add_b0),
        .i_add_sum (sum_in0),
        .o_valid   (o_valid0),
        .i_ready   (r0),
        .o_sum     (o_sum0)
    );

    adder_stream #(.LATENCY(3), .DEPTH(8)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_valid   (v1),
        .o_ready   (o_ready1),
        .i_a       (a1),
        .i_b       (b1),
        .o_add_a   (o_add_a1),
        .o_add_b   (o_add_b1),
        .i_add_sum (sum_in1),
        .o_valid   (o_valid1),
        .i_ready   (r1),
        .o_sum     (o_sum1)
    );

    // Adder models: registered sum, LATENCY stages deep.
    always @(posedge clk) begin
        add0_q    <= {1'b0, o_add_a0} + {1'b0, o_add_b0};
        add1_q[0] <= {1'b0, o_add_a1} + {1'b0, o_add_b1};
        add1_q[1] <= add1_q[0];
        add1_q[2] <= add1_q[1];
    end
    assign sum_in0 = add0_q;
    assign sum_in1 = add1_q[2];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // A FIFO write while full must never be requested.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("overflow0", 32'(dut0.fifo_push && dut0.fifo_full), 0);
            chk("overflow1", 32'(dut1.fifo_push && dut1.fifo_full), 0);
        end
    end

    initial begin
        rst_n = 1'b0;
        v0 = 0; r0 = 0; a0 = '0; b0 = '0;
        v1 = 0; r1 = 0; a1 = '0; b1 = '0;
        tick();
        tick();
        chk("rst_ready",  o_ready0, 0);
        chk("rst_valid",  o_valid0, 0);
        chk("rst_add_a",  o_add_a0, 0);
        chk("rst_add_b",  o_add_b0, 0);
        chk("rst_sum",    o_sum0,   0);
        chk("rst_ready1", o_ready1, 0);
        rst_n = 1'b1;
        tick();
        chk("ready_rise", o_ready0, 1);

        // Single add with full carry-out.
        v0 = 1; a0 = 16'hFFFF; b0 = 16'h0001; r0 = 1;
        tick();
        v0 = 0;
        chk("add_a_load", o_add_a0, 16'hFFFF);
        chk("add_b_load", o_add_b0, 16'h0001);
        chk("single_e0",  o_valid0, 0);
        tick();
        chk("single_e1",  o_valid0, 0);
        tick();
        chk("single_v",   o_valid0, 1);
        chk("single_sum", o_sum0,   17'h10000);
        tick();
        chk("single_pop", o_valid0, 0);

        // Streaming: pairs n, 2n give 3n one per cycle.
        for (int j = 0; j < 20; j++) begin
            chk("stream_valid", o_valid0, 32'(j >= 3 && j <= 18));
            if (j >= 3 && j <= 18) begin
                chk("stream_sum", o_sum0, 32'(3 * (j - 2)));
            end
            if (j < 16) begin
                chk("stream_ready", o_ready0, 1);
                v0 = 1;
                a0 = 16'(j + 1);
                b0 = 16'(2 * (j + 1));
            end else begin
                v0 = 0;
            end
            tick();
        end

        // Backpressure: only DEPTH operations taken while stalled.
        r0 = 0;
        k  = 0;
        for (int c = 0; c < 10; c++) begin
            chk("bp_ready", o_ready0, 32'(c < 4));
            v0 = 1;
            a0 = 16'hF000 + 16'(k);
            b0 = 16'h1000 + 16'(k);
            if (o_ready0) k++;
            tick();
        end
        chk("bp_accepted",  k, 4);
        chk("bp_ready_low", o_ready0, 0);
        r0 = 1;
        rx = 0;
        for (int c = 0; c < 40 && (rx < 10 || k < 10); c++) begin
            v0 = (k < 10);
            a0 = 16'hF000 + 16'(k);
            b0 = 16'h1000 + 16'(k);
            if (o_valid0) begin
                chk("bp_sum", o_sum0, 32'h10000 + 32'(2 * rx));
                rx++;
            end
            if (v0 && o_ready0) k++;
            tick();
        end
        v0 = 0;
        chk("bp_count", rx, 10);
        chk("bp_taken", k, 10);
        chk("bp_empty", o_valid0, 0);

        // Capture and pop on one edge: head advances, order kept.
        r0 = 0;
        for (int c = 0; c < 3; c++) begin
            v0 = 1;
            a0 = 16'(c * 16'h11);
            b0 = 16'h0100;
            tick();
        end
        chk("pp_head0", o_sum0, 17'h00100);
        v0 = 1; a0 = 16'h0033; b0 = 16'h0100; r0 = 1;
        tick();
        v0 = 0; r0 = 0;
        chk("pp_valid", o_valid0, 1);
        chk("pp_head1", o_sum0,   17'h00111);
        chk("pp_ready", o_ready0, 1);
        tick();
        tick();
        r0 = 1;
        for (int e = 1; e < 4; e++) begin
            chk("pp_valid_d", o_valid0, 1);
            chk("pp_order",   o_sum0,   32'h100 + 32'(e * 16'h11));
            tick();
        end
        chk("pp_empty", o_valid0, 0);

        // Mid-flight reset discards everything in flight.
        for (int c = 0; c < 3; c++) begin
            v0 = 1;
            a0 = 16'h0AAA;
            b0 = 16'(c);
            tick();
        end
        v0 = 0;
        rst_n = 1'b0;
        #1;
        chk("mr_valid",  o_valid0, 0);
        chk("mr_ready",  o_ready0, 0);
        chk("mr_add_a",  o_add_a0, 0);
        chk("mr_add_b",  o_add_b0, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("mr_ready_rise", o_ready0, 1);
        for (int c = 0; c < 4; c++) begin
            chk("mr_no_stale", o_valid0, 0);
            tick();
        end
        v0 = 1; a0 = 16'd5; b0 = 16'd7;
        tick();
        v0 = 0;
        tick();
        tick();
        chk("mr_fresh_v",   o_valid0, 1);
        chk("mr_fresh_sum", o_sum0,   17'h0000C);
        tick();
        chk("mr_fresh_pop", o_valid0, 0);

        // Random traffic on LATENCY=3, DEPTH=8 against a scoreboard.
        for (int c = 0; c < 600; c++) begin
            v1 = 1'($urandom_range(0, 1));
            a1 = 16'($urandom);
            b1 = 16'($urandom);
            r1 = (c < 300) ? 1'b1 : 1'($urandom_range(0, 1));
            if (c < 300) chk("rnd_ready", o_ready1, 1);
            if (o_valid1 && r1) begin
                chk("rnd_nonempty", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    chk("rnd_sum", o_sum1, exp_q[0]);
                    if (c < 300) begin
                        chk("rnd_lat", c - cyc_q[0], 5);
                    end else begin
                        chk("rnd_lat_min", 32'(c - cyc_q[0] >= 5), 1);
                    end
                    void'(exp_q.pop_front());
                    void'(cyc_q.pop_front());
                end
            end
            if (v1 && o_ready1) begin
                exp_q.push_back({1'b0, a1} + {1'b0, b1});
                cyc_q.push_back(c);
            end
            tick();
        end
        v1 = 0;
        r1 = 1;
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) begin
            if (o_valid1) begin
                chk("drain_sum", o_sum1, exp_q[0]);
                void'(exp_q.pop_front());
                void'(cyc_q.pop_front());
            end
            tick();
        end
        chk("rnd_drained", exp_q.size(), 0);
        chk("rnd_empty",   o_valid1, 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
